// File: rtl/apb_arb2_pkg.sv
// apb_arb2 shared types: FSM encoding and default APB widths.
package apb_arb2_pkg;

  localparam int ADDR_APB    = 32;
  localparam int DATA_APB_32 = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

endpackage

// File: rtl/apb_arb2_if.sv
// One APB port with the arbiter's one-cycle ack.
interface apb_arb2_if
  import apb_arb2_pkg::*;
#(
  parameter int AW = ADDR_APB,
  parameter int DW = DATA_APB_32
);
  logic          psel;
  logic          penable;
  logic [AW-1:0] paddr;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          ack;

  modport master (
    output psel, penable, paddr,
    output pwrite, pwdata,
    input  prdata, ack
  );

  modport slave (
    input  psel, penable, paddr,
    input  pwrite, pwdata,
    output prdata, ack
  );
endinterface

// File: rtl/apb_arb2_rr_pick2.sv
// Two-way round-robin pick: with both requesting,
// the master that did not win last time goes.
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       win_o
);
  always_comb begin
    win_o = 1'b0;
    unique case (req_i)
      2'b11:   win_o = ~last_i;
      2'b10:   win_o = 1'b1;
      default: win_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/apb_arb2.sv
// Two-master APB arbiter in front of one
// zero-wait-state APB slave.
module apb_arb2
  import apb_arb2_pkg::*;
#(
  parameter int ADDR_W = ADDR_APB,
  parameter int DATA_W = DATA_APB_32
) (
  input  logic              apb_pclk,
  input  logic              apb_prstn,
  input  logic              m0_psel,
  input  logic              m0_penable,
  input  logic [ADDR_W-1:0] m0_paddr,
  input  logic              m0_pwrite,
  input  logic [DATA_W-1:0] m0_pwdata,
  output logic [DATA_W-1:0] m0_prdata,
  output logic              m0_ack,
  input  logic              m1_psel,
  input  logic              m1_penable,
  input  logic [ADDR_W-1:0] m1_paddr,
  input  logic              m1_pwrite,
  input  logic [DATA_W-1:0] m1_pwdata,
  output logic [DATA_W-1:0] m1_prdata,
  output logic              m1_ack,
  output logic              s_psel,
  output logic              s_penable,
  output logic [ADDR_W-1:0] s_paddr,
  output logic              s_pwrite,
  output logic [DATA_W-1:0] s_pwdata,
  input  logic [DATA_W-1:0] s_prdata,
  output logic              gnt
);

  state_e            state_q, state_d;
  logic              last_q, gnt_q;
  logic [ADDR_W-1:0] paddr_q;
  logic              pwrite_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [1:0]        req;
  logic              win;
  logic              load;
  logic              in_acc;
  logic              unused_penable;

  assign unused_penable = m0_penable ^ m1_penable;

  // the granted master's request is still up
  // during its own ACCESS cycle; hide it
  assign in_acc = (state_q == ACCESS);
  assign req = {m1_psel & ~(in_acc & gnt_q),
                m0_psel & ~(in_acc & ~gnt_q)};

  rr_pick2 u_pick (
    .req_i  (req),
    .last_i (last_q),
    .win_o  (win)
  );

  always_ff @(posedge apb_pclk) begin
    if (!apb_prstn) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  state_d = (|req) ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign load = (state_d == SETUP) &&
                (state_q != SETUP);

  always_ff @(posedge apb_pclk) begin
    if (!apb_prstn) begin
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
    end else if (load) begin
      last_q   <= win;
      gnt_q    <= win;
      paddr_q  <= win ? m1_paddr  : m0_paddr;
      pwrite_q <= win ? m1_pwrite : m0_pwrite;
      pwdata_q <= win ? m1_pwdata : m0_pwdata;
    end
  end

  always_comb begin
    s_psel    = (state_q != IDLE);
    s_penable = in_acc;
    s_paddr   = paddr_q;
    s_pwrite  = pwrite_q;
    s_pwdata  = pwdata_q;
    gnt       = gnt_q;
    m0_ack    = in_acc & ~gnt_q;
    m1_ack    = in_acc & gnt_q;
    m0_prdata = m0_ack ? s_prdata : '0;
    m1_prdata = m1_ack ? s_prdata : '0;
  end

endmodule

// File: tb/tb_apb_arb2.sv
// Randomized and directed bench for apb_arb2
// against a transfer-level reference model.
module tb_apb_arb2;
  import apb_arb2_pkg::*;

  typedef logic [133:0] vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic gnt;
  int   n_chk = 0;
  int   n_fail = 0;

  apb_arb2_if m0_bus ();
  apb_arb2_if m1_bus ();
  apb_arb2_if s_bus ();

  assign s_bus.ack = 1'b0;

  always #5 clk = ~clk;

  apb_arb2 dut (
    .apb_pclk   (clk),
    .apb_prstn  (rst_n),
    .m0_psel    (m0_bus.psel),
    .m0_penable (m0_bus.penable),
    .m0_paddr   (m0_bus.paddr),
    .m0_pwrite  (m0_bus.pwrite),
    .m0_pwdata  (m0_bus.pwdata),
    .m0_prdata  (m0_bus.prdata),
    .m0_ack     (m0_bus.ack),
    .m1_psel    (m1_bus.psel),
    .m1_penable (m1_bus.penable),
    .m1_paddr   (m1_bus.paddr),
    .m1_pwrite  (m1_bus.pwrite),
    .m1_pwdata  (m1_bus.pwdata),
    .m1_prdata  (m1_bus.prdata),
    .m1_ack     (m1_bus.ack),
    .s_psel     (s_bus.psel),
    .s_penable  (s_bus.penable),
    .s_paddr    (s_bus.paddr),
    .s_pwrite   (s_bus.pwrite),
    .s_pwdata   (s_bus.pwdata),
    .s_prdata   (s_bus.prdata),
    .gnt        (gnt)
  );

  // reference: cycles left in the current transfer
  int          mb;
  logic        mown, mlast, mwr;
  logic [31:0] maddr, mdata;

  // master-side stimulus state
  int          want [2];
  logic        ack_seen [2];
  logic [31:0] nxt_addr [2];
  logic [31:0] nxt_data [2];
  logic        nxt_wr [2];
  logic        rand_fields;

  function automatic vec_t model_vec();
    logic a0, a1;
    a0 = (mb == 1) && (mown == 1'b0);
    a1 = (mb == 1) && (mown == 1'b1);
    return {mb != 0, mb == 1, mwr, maddr, mdata,
            mown, a0, a1,
            a0 ? s_bus.prdata : 32'h0,
            a1 ? s_bus.prdata : 32'h0};
  endfunction

  function automatic vec_t dut_vec();
    return {s_bus.psel, s_bus.penable,
            s_bus.pwrite, s_bus.paddr,
            s_bus.pwdata, gnt,
            m0_bus.ack, m1_bus.ack,
            m0_bus.prdata, m1_bus.prdata};
  endfunction

  task automatic model_update();
    logic fin, e0, e1, w;
    if (!rst_n) begin
      mb = 0; mown = 0; mlast = 1;
      maddr = 0; mdata = 0; mwr = 0;
    end else if (mb == 2) begin
      mb = 1;
    end else begin
      fin = (mb == 1);
      e0 = m0_bus.psel && !(fin && !mown);
      e1 = m1_bus.psel && !(fin && mown);
      if (e0 || e1) begin
        w = (e0 && e1) ? ~mlast : e1;
        mown = w; mlast = w; mb = 2;
        maddr = w ? m1_bus.paddr : m0_bus.paddr;
        mdata = w ? m1_bus.pwdata : m0_bus.pwdata;
        mwr = w ? m1_bus.pwrite : m0_bus.pwrite;
      end else begin
        mb = 0;
      end
    end
  endtask

  task automatic drive_masters();
    logic cur, go;
    for (int i = 0; i < 2; i++) begin
      if (ack_seen[i] && want[i] > 0)
        want[i] = want[i] - 1;
      cur = (i == 0) ? m0_bus.psel : m1_bus.psel;
      go = want[i] > 0 && (!cur || ack_seen[i]);
      if (i == 0) begin
        m0_bus.psel = want[0] > 0;
        if (go) begin
          m0_bus.paddr = nxt_addr[0];
          m0_bus.pwdata = nxt_data[0];
          m0_bus.pwrite = nxt_wr[0];
        end
      end else begin
        m1_bus.psel = want[1] > 0;
        if (go) begin
          m1_bus.paddr = nxt_addr[1];
          m1_bus.pwdata = nxt_data[1];
          m1_bus.pwrite = nxt_wr[1];
        end
      end
      if (go && rand_fields) begin
        nxt_addr[i] = $urandom;
        nxt_data[i] = $urandom;
        nxt_wr[i] = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    drive_masters();
    @(negedge clk);
    ack_seen[0] = m0_bus.ack;
    ack_seen[1] = m1_bus.ack;
  endtask

  task automatic start_req();
    ack_seen[0] = 0;
    ack_seen[1] = 0;
    drive_masters();
  endtask

  task automatic test_reset();
    int a0, a1;
    a0 = -1; a1 = -1;
    want[0] = 1; want[1] = 1;
    rst_n = 0;
    start_req();
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_chk++;
      if (dut_vec() !== '0) begin
        n_fail++;
        $display("FAIL reset_zero got=%h want=0",
                 dut_vec());
      end
    end
    rst_n = 1;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      if (m0_bus.ack && a0 < 0) a0 = k;
      if (m1_bus.ack && a1 < 0) a1 = k;
      n_chk++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL reset_rel k=%0d got=%h want=%h",
                 k, dut_vec(), model_vec());
      end
    end
    n_chk++;
    if (a0 !== 2 || a1 !== 4) begin
      n_fail++;
      $display("FAIL reset_first got=%0d/%0d want=2/4",
               a0, a1);
    end
  endtask

  task automatic test_m0_write();
    int acks0, acks1, at;
    acks0 = 0; acks1 = 0; at = -1;
    nxt_addr[0] = 32'h1F0E0004;
    nxt_data[0] = 32'hA5;
    nxt_wr[0] = 1;
    want[0] = 1;
    start_req();
    for (int k = 1; k <= 5; k++) begin
      cycle();
      if (m0_bus.ack) begin acks0++; at = k; end
      if (m1_bus.ack) acks1++;
      n_chk++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL m0_wr_model k=%0d got=%h want=%h",
                 k, dut_vec(), model_vec());
      end
      if (k == 1) begin
        n_chk++;
        if ({s_bus.psel, s_bus.penable} !== 2'b10)
        begin
          n_fail++;
          $display("FAIL m0_wr_setup got=%b want=10",
                   {s_bus.psel, s_bus.penable});
        end
      end
      if (k == 2) begin
        n_chk++;
        if ({s_bus.paddr, s_bus.pwdata,
             s_bus.pwrite} !==
            {32'h1F0E0004, 32'hA5, 1'b1}) begin
          n_fail++;
          $display("FAIL m0_wr_bus got=%h %h %b",
                   s_bus.paddr, s_bus.pwdata,
                   s_bus.pwrite);
        end
      end
    end
    n_chk++;
    if (acks0 !== 1 || at !== 2 || acks1 !== 0) begin
      n_fail++;
      $display("FAIL m0_wr_ack got=%0d@%0d m1=%0d want=1@2 m1=0",
               acks0, at, acks1);
    end
  endtask

  task automatic test_m1_read();
    int acks;
    acks = 0;
    s_bus.prdata = 32'h3C;
    nxt_addr[1] = 32'h1F0E0010;
    nxt_data[1] = 32'h0;
    nxt_wr[1] = 0;
    want[1] = 1;
    start_req();
    for (int k = 1; k <= 5; k++) begin
      cycle();
      if (m1_bus.ack) acks++;
      n_chk++;
      if (m1_bus.prdata !==
          (m1_bus.ack ? 32'h3C : 32'h0) ||
          m0_bus.prdata !== 32'h0) begin
        n_fail++;
        $display("FAIL m1_rd_data k=%0d got=%h/%h ack=%b",
                 k, m1_bus.prdata, m0_bus.prdata,
                 m1_bus.ack);
      end
      n_chk++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL m1_rd_model k=%0d got=%h want=%h",
                 k, dut_vec(), model_vec());
      end
    end
    n_chk++;
    if (acks !== 1) begin
      n_fail++;
      $display("FAIL m1_rd_ack got=%0d want=1", acks);
    end
  endtask

  task automatic test_contention();
    int t0[$], t1[$], ord[$], idle, bad;
    idle = 0; bad = 0;
    rand_fields = 1;
    want[0] = 4; want[1] = 4;
    start_req();
    for (int k = 1; k <= 20; k++) begin
      cycle();
      if (m0_bus.ack) begin t0.push_back(k); ord.push_back(0); end
      if (m1_bus.ack) begin t1.push_back(k); ord.push_back(1); end
      if (k <= 16 && !s_bus.psel) idle++;
      n_chk++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL cont_model k=%0d got=%h want=%h",
                 k, dut_vec(), model_vec());
      end
    end
    for (int i = 1; i < ord.size(); i++)
      if (ord[i] == ord[i-1]) bad++;
    for (int i = 1; i < t0.size(); i++)
      if (t0[i] - t0[i-1] != 4) bad++;
    for (int i = 1; i < t1.size(); i++)
      if (t1[i] - t1[i-1] != 4) bad++;
    n_chk++;
    if (t0.size() != 4 || t1.size() != 4 ||
        bad != 0 || idle != 0) begin
      n_fail++;
      $display("FAIL contention n=%0d/%0d bad=%0d idle=%0d want 4/4 0 0",
               t0.size(), t1.size(), bad, idle);
    end
  endtask

  task automatic test_back_to_back();
    int t0[$], bad;
    bad = 0;
    want[0] = 3;
    start_req();
    for (int k = 1; k <= 12; k++) begin
      cycle();
      if (m0_bus.ack) t0.push_back(k);
      n_chk++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL b2b_model k=%0d got=%h want=%h",
                 k, dut_vec(), model_vec());
      end
    end
    for (int i = 1; i < t0.size(); i++)
      if (t0[i] - t0[i-1] != 3) bad++;
    n_chk++;
    if (t0.size() != 3 || bad != 0) begin
      n_fail++;
      $display("FAIL b2b_spacing n=%0d bad=%0d want 3 0",
               t0.size(), bad);
    end
  endtask

  task automatic test_reset_mid();
    want[0] = 1; want[1] = 1;
    start_req();
    cycle();
    n_chk++;
    if ({s_bus.psel, s_bus.penable, gnt} !== 3'b101)
    begin
      n_fail++;
      $display("FAIL rmid_setup got=%b want=101",
               {s_bus.psel, s_bus.penable, gnt});
    end
    rst_n = 0;
    cycle();
    n_chk++;
    if (dut_vec() !== '0) begin
      n_fail++;
      $display("FAIL rmid_zero got=%h want=0",
               dut_vec());
    end
    rst_n = 1;
    cycle();
    n_chk++;
    if ({s_bus.psel, s_bus.penable, gnt} !== 3'b100)
    begin
      n_fail++;
      $display("FAIL rmid_prio got=%b want=100",
               {s_bus.psel, s_bus.penable, gnt});
    end
    for (int k = 0; k < 6; k++) begin
      cycle();
      n_chk++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL rmid_model k=%0d got=%h want=%h",
                 k, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (want[i] > 0 && $urandom_range(0, 24) == 0)
          want[i] = 0;
        else if (want[i] == 0 &&
                 $urandom_range(0, 2) == 0)
          want[i] = $urandom_range(1, 3);
      end
      s_bus.prdata = $urandom;
      m0_bus.penable = 1'($urandom_range(0, 1));
      m1_bus.penable = 1'($urandom_range(0, 1));
      cycle();
      n_chk++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL random k=%0d got=%h want=%h",
                 k, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    rand_fields = 0;
    want[0] = 0; want[1] = 0;
    ack_seen[0] = 0; ack_seen[1] = 0;
    for (int i = 0; i < 2; i++) begin
      nxt_addr[i] = 32'h100 + i;
      nxt_data[i] = 32'h55 + i;
      nxt_wr[i] = 1;
    end
    m0_bus.psel = 0; m0_bus.penable = 0;
    m0_bus.paddr = 0; m0_bus.pwrite = 0;
    m0_bus.pwdata = 0;
    m1_bus.psel = 0; m1_bus.penable = 0;
    m1_bus.paddr = 0; m1_bus.pwrite = 0;
    m1_bus.pwdata = 0;
    s_bus.prdata = 0;
    mb = 0; mown = 0; mlast = 1;
    maddr = 0; mdata = 0; mwr = 0;
    @(negedge clk);
    test_reset();
    test_m0_write();
    test_m1_read();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
